quad_sample_collector: RTL and testbench
========================================

Name: quad_sample_collector

Overview:
- Sequential front end for the four-input second-largest selector.
- Accepts a serial stream of 4-bit samples over a valid/ready handshake and groups them into frames of four.
- Presents each frame as four parallel registered lanes that drive the selector's in1..in4, with a valid/ready handshake and a frame counter.
- Double-buffered (collect buffer + output buffer) so the stream sustains one sample per cycle when the consumer is always ready.

Parameters:
- WIDTH, 4, sample width in bits. The downstream selector requires 4.
- CNT_W, 8, width of frame counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- s_valid  input  1  s_data holds a sample
- s_data  input  WIDTH  sample
- s_flush  input  1  close the current frame early; unused lanes are zero-padded
- s_ready  output  1  block can accept a sample/flush this cycle
- m_valid  output  1  out1..out4 hold a frame
- m_ready  input  1  consumer takes the frame
- out1  output  WIDTH  first sample of frame
- out2  output  WIDTH  second sample
- out3  output  WIDTH  third sample
- out4  output  WIDTH  fourth sample
- m_lanes  output  3  number of real samples in frame (1..4)
- frame_cnt  output  CNT_W  frames delivered, wraps

Behaviour:
Reset (rst high at a clock edge):
- All registers clear: fill index 0, pending 0, m_valid 0, out1..out4 0, m_lanes 0, frame_cnt 0.
- s_ready is 0 while rst is high and 1 on the first cycle after release.

Collect stage:
- Fill index idx counts 0..3; lane registers c0..c3; pending flag.
- Accept: s_valid && s_ready at a clock edge writes s_data into c[idx].
  - If idx==3, pending sets and idx returns to 0.
  - Otherwise idx increments.
- Flush: s_flush && s_ready at a clock edge.
  - With a same-cycle sample: the sample is stored first.
  - Pending sets if at least one real sample is in the frame; lanes above the last real sample become 0; idx returns to 0.
  - Flush with idx==0 and no same-cycle sample: ignored, no empty frame is emitted.
  - Flush coincident with the 4th sample: identical to a normal full frame.
- Lane count: frame lane count = real samples (1..4), stored alongside the frame.

Transfer and readiness:
- free = !m_valid || m_ready.
- Transfer: on any edge where pending && free, c0..c3 and the lane count copy into out1..out4 and m_lanes; m_valid is 1 the following cycle; pending clears.
- s_ready = !pending || free. A sample accepted on the same edge as a transfer goes into c0 of the next frame.
- Latency: 4th sample accepted at edge N, frame visible on out1..out4 after edge N+1 when the output is free.
- Stall: while pending && !free, s_ready = 0 and s_flush is ignored; c0..c3 hold.

Output stage:
- Output handshake: m_valid && m_ready at an edge increments frame_cnt, wrapping from 2^CNT_W-1 to 0.
  - m_valid stays 1 if a transfer happens on the same edge; otherwise it drops to 0.
- While m_valid && !m_ready, out1..out4 and m_lanes are stable.
- Mid-operation reset discards partial frames, pending frames and the presented frame.
- s_data/s_flush are don't-care when not accepted.
- Lane order: first accepted sample → out1.

Test Plan:
- Full-rate stream: m_ready=1, s_valid continuous with 3,9,5,9,1,2,14,7 → frame 1 = (3,9,5,9), m_lanes=4, m_valid high the cycle after the 5th edge; frame 2 = (1,2,14,7); s_ready never drops; frame_cnt=2.
- Backpressure: m_ready=0 with 8 samples offered → first frame held on out1..out4; second frame pending; s_ready=0 from the cycle after the 8th accept. Release m_ready → frame 2 appears the next cycle, s_ready returns to 1.
- Partial flush: samples 6,11 then s_flush alone → frame (6,11,0,0), m_lanes=2. A flush with idx==0 and s_valid=0 emits nothing.
- Flush with sample: s_flush and s_valid on the 3rd sample (4,8,12) → frame (4,8,12,0), m_lanes=3.
- Reset mid-frame: assert rst after 2 samples while a frame is presented → m_valid=0, frame_cnt=0, outputs 0. The next 4 samples form a clean frame starting at out1.
- Counter wrap: deliver 256 frames → frame_cnt reads 0, with no effect on data.

Source files
------------

// File: rtl/quad_sample_collector.sv
`default_nettype none
// ============================================================================
// Module   : quad_sample_collector
// Purpose  : Serial-to-parallel front end for the four-input second-largest
//            selector. Groups a valid/ready stream of samples into frames of
//            four and presents each frame on four registered lanes. A frame
//            can be closed early with s_flush, which zero-pads the unused
//            lanes. A collect buffer and an output buffer let the stream run
//            at one sample per cycle when the consumer is always ready.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            s_valid/s_data/s_ready/s_flush - input sample stream
//            m_valid/m_ready      - output frame handshake
//            out1..out4           - frame lanes, out1 = first sample
//            m_lanes              - number of real samples in frame (1..4)
//            frame_cnt            - frames delivered, wrapping
// Revision : 1.0 - initial release
// ============================================================================
module quad_sample_collector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_flush,
    output logic             s_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [2:0]       m_lanes,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [1:0] c_last_idx = 2'd3;

    // Collect buffer
    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_c [4];
    logic [2:0]       r_c_lanes;
    logic             r_pending;

    // Output buffer
    logic [WIDTH-1:0] r_out [4];
    logic [2:0]       r_m_lanes;
    logic             r_m_valid;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_free;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_flush;
    logic             w_transfer;
    logic             w_close;
    logic [2:0]       w_cnt;

    // The output slot can take a new frame when empty or being emptied now.
    assign w_free     = !r_m_valid || m_ready;
    assign w_s_ready  = !rst && (!r_pending || w_free);
    assign w_accept   = s_valid && w_s_ready;
    assign w_flush    = s_flush && w_s_ready;
    assign w_transfer = r_pending && w_free;

    // Real samples in the current frame once this cycle's sample is counted.
    assign w_cnt      = {1'b0, r_idx} + {2'b00, w_accept};

    // A frame closes when the 4th sample lands, or on a flush that has at
    // least one real sample; a flush on an empty frame is dropped.
    assign w_close    = (w_accept && (r_idx == c_last_idx)) ||
                        (w_flush && (w_cnt != 3'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_c_lanes   <= '0;
            r_pending   <= 1'b0;
            r_m_lanes   <= '0;
            r_m_valid   <= 1'b0;
            r_frame_cnt <= '0;
            for (int k = 0; k < 4; k++) begin
                r_c[k]   <= '0;
                r_out[k] <= '0;
            end
        end else begin
            // Collect stage. When a sample is accepted on the same edge as a
            // transfer, the old c0..c3 are copied out below before this
            // write becomes visible, so the sample starts the next frame.
            if (w_accept) begin
                r_c[r_idx] <= s_data;
            end

            if (w_close) begin
                // Zero-pad lanes above the last real sample. The lane just
                // written this cycle is always below w_cnt, so no overlap.
                for (int k = 0; k < 4; k++) begin
                    if (3'(k) >= w_cnt) begin
                        r_c[k] <= '0;
                    end
                end
                r_idx     <= '0;
                r_c_lanes <= w_cnt;
            end else if (w_accept) begin
                r_idx <= r_idx + 2'd1;
            end

            // A newly closed frame outranks the clear from a transfer.
            if (w_close) begin
                r_pending <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end

            // Output stage
            if (w_transfer) begin
                for (int k = 0; k < 4; k++) begin
                    r_out[k] <= r_c[k];
                end
                r_m_lanes <= r_c_lanes;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            if (r_m_valid && m_ready) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign s_ready   = w_s_ready;
    assign m_valid   = r_m_valid;
    assign out1      = r_out[0];
    assign out2      = r_out[1];
    assign out3      = r_out[2];
    assign out4      = r_out[3];
    assign m_lanes   = r_m_lanes;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_quad_sample_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_sample_collector
// Purpose  : Self-checking bench for quad_sample_collector. A driver issues
//            directed and random traffic and pushes each completed frame into
//            a scoreboard queue; a separate monitor pops and compares whenever
//            the DUT hands over a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_sample_collector;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_flush = 1'b0;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] out1, out2, out3, out4;
    logic [2:0]       m_lanes;
    logic [CNT_W-1:0] frame_cnt;

    quad_sample_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_flush   (s_flush),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .m_lanes   (m_lanes),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // d[3:0] is the first sample of the frame.
    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  lanes;
    } frame_t;

    frame_t     sb_q[$];   // frames completed, not yet handed over
    logic [3:0] cur[$];    // samples of the frame being collected
    int         pend;      // completed frames waiting for the output slot
    bit         pres;      // a frame is being presented
    int         exp_cnt;   // frames handed over since reset
    int         checks;
    int         errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model advances over the edge that
    // follows.
    task automatic cyc(input bit v, input logic [3:0] d, input bit f, input bit mr);
        bit     free, ready, acc, done;
        frame_t fr;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        s_flush = f;
        m_ready = mr;
        #1;
        free  = !pres || mr;
        ready = (pend == 0) || free;
        chk("s_ready", 32'(s_ready), 32'(ready));
        chk("m_valid", 32'(m_valid), 32'(pres));
        acc = v && ready;
        if (acc) cur.push_back(d);
        done = (acc && cur.size() == 4) || (f && ready && cur.size() > 0);
        if (pend > 0 && free) begin
            pend--;
            pres = 1'b1;
        end else if (pres && mr) begin
            pres = 1'b0;
        end
        if (done) begin
            fr.d = '0;
            for (int i = 0; i < cur.size(); i++) fr.d[4*i +: 4] = cur[i];
            fr.lanes = 3'(cur.size());
            sb_q.push_back(fr);
            cur.delete();
            pend++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        s_flush = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("s_ready_in_rst", 32'(s_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("s_ready_in_rst2", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_out", {16'd0, out4, out3, out2, out1}, 32'd0);
        chk("rst_m_lanes", 32'(m_lanes), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        sb_q.delete();
        cur.delete();
        pend    = 0;
        pres    = 1'b0;
        exp_cnt = 0;
    endtask

    // Monitor: compares every handed-over frame against the scoreboard.
    initial begin
        frame_t fr;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got out=%h%h%h%h lanes=%0d expected no frame",
                             out4, out3, out2, out1, m_lanes);
                end else begin
                    fr = sb_q.pop_front();
                    chk("out1", 32'(out1), 32'(fr.d[3:0]));
                    chk("out2", 32'(out2), 32'(fr.d[7:4]));
                    chk("out3", 32'(out3), 32'(fr.d[11:8]));
                    chk("out4", 32'(out4), 32'(fr.d[15:12]));
                    chk("m_lanes", 32'(m_lanes), 32'(fr.lanes));
                    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt % 256));
                    exp_cnt++;
                end
            end
        end
    end

    initial begin
        logic [3:0] stream [8];
        checks = 0;
        errors = 0;
        pend   = 0;
        pres   = 1'b0;
        exp_cnt = 0;
        stream = '{4'd3, 4'd9, 4'd5, 4'd9, 4'd1, 4'd2, 4'd14, 4'd7};

        do_reset();

        // Full-rate stream, consumer always ready.
        for (int i = 0; i < 8; i++) cyc(1'b1, stream[i], 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("full_rate_frame_cnt", 32'(frame_cnt), 32'd2);

        // Backpressure: 8 samples with the consumer stalled, then release.
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i + 5), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);

        // Partial flush, then a flush on an empty frame.
        cyc(1'b1, 4'd6, 1'b0, 1'b1);
        cyc(1'b1, 4'd11, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);

        // Flush together with the 3rd sample.
        cyc(1'b1, 4'd4, 1'b0, 1'b1);
        cyc(1'b1, 4'd8, 1'b0, 1'b1);
        cyc(1'b1, 4'd12, 1'b1, 1'b1);
        // Flush together with the 4th sample behaves as a full frame.
        cyc(1'b1, 4'd1, 1'b0, 1'b1);
        cyc(1'b1, 4'd2, 1'b0, 1'b1);
        cyc(1'b1, 4'd3, 1'b0, 1'b1);
        cyc(1'b1, 4'd4, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);

        // Reset with a frame presented and two samples collected.
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i + 9), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 2), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);

        // Counter wrap: exactly 256 frames from reset.
        do_reset();
        for (int i = 0; i < 1024; i++) cyc(1'b1, 4'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        chk("wrap_frames", 32'(exp_cnt), 32'd256);

        // Random traffic with random backpressure and flushes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 4'($urandom),
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
